// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder: format codes,
// FSM states, request record and per-format immediate ranges.
package instr_encoder_pkg;

  // Same encoding as the extender's Imm_src select.
  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_J = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ENCODE = 2'b01,
    ST_WRITE  = 2'b10,
    ST_ERROR  = 2'b11
  } state_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } req_t;

  localparam int IMM_IS_MIN = -2048;
  localparam int IMM_IS_MAX = 2047;
  localparam int IMM_B_MIN  = -4096;
  localparam int IMM_B_MAX  = 4094;
  localparam int IMM_J_MIN  = -1048576;
  localparam int IMM_J_MAX  = 1048574;

endpackage

// File: rtl/instr_encoder_if.sv
// Request port (decoded fields in) and instruction-memory write port.
interface instr_encoder_if #(parameter int ADDR_WIDTH = 10);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_fmt;
  logic [6:0]            in_opcode;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [2:0]            in_funct3;
  logic [31:0]           in_imm;
  logic                  mem_we;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm,
    input  mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm,
    output mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational RV32I packer: scatters the immediate into the format's bit
// positions and flags immediates that the format cannot represent.
module imm_pack
  import instr_encoder_pkg::*;
(
  input  req_t        req_i,
  output logic [31:0] word_o,
  output logic        legal_o
);
  logic signed [31:0] s;
  logic [31:0]        im;

  always_comb begin
    im      = req_i.imm;
    s       = $signed(req_i.imm);
    word_o  = '0;
    legal_o = 1'b0;
    case (req_i.fmt)
      FMT_I: begin
        word_o  = {im[11:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
        legal_o = (s >= IMM_IS_MIN) && (s <= IMM_IS_MAX);
      end
      FMT_S: begin
        word_o  = {im[11:5], req_i.rs2, req_i.rs1, req_i.funct3, im[4:0], req_i.opcode};
        legal_o = (s >= IMM_IS_MIN) && (s <= IMM_IS_MAX);
      end
      FMT_B: begin
        word_o  = {im[12], im[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                   im[4:1], im[11], req_i.opcode};
        legal_o = (s >= IMM_B_MIN) && (s <= IMM_B_MAX) && !im[0];
      end
      FMT_J: begin
        word_o  = {im[20], im[10:1], im[11], im[19:12], req_i.rd, req_i.opcode};
        legal_o = (s >= IMM_J_MIN) && (s <= IMM_J_MAX) && !im[0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// Accepts decoded fields, encodes one RV32I word per request and streams it
// into instruction memory at consecutive word addresses.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  instr_encoder_if.slave        bus,
  output logic                  err,
  output logic [ADDR_WIDTH-2:0] word_count,
  output logic                  full
);
  localparam int                  CW  = ADDR_WIDTH - 1;
  localparam logic [CW-1:0]       CAP = CW'(2 ** (ADDR_WIDTH - 2));

  state_e                state_q, state_d;
  req_t                  req_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         cnt_q;
  logic                  run_q;
  logic [31:0]           word;
  logic                  legal;
  logic                  accept;

  imm_pack u_pack (.req_i(req_q), .word_o(word), .legal_o(legal));

  assign full          = (cnt_q == CAP);
  // run_q keeps in_ready low while reset is (or has just been) asserted.
  assign bus.in_ready  = run_q && (state_q == ST_IDLE) && !full && !clear;
  assign accept        = bus.in_ready && bus.in_valid;
  assign bus.mem_we    = (state_q == ST_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign err           = (state_q == ST_ERROR);
  assign word_count    = cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ENCODE;
      ST_ENCODE: state_d = legal ? ST_WRITE : ST_ERROR;
      ST_WRITE:  if (bus.mem_ready) state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      wdata_q <= '0;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (accept)
        req_q <= '{fmt: fmt_e'(bus.in_fmt), opcode: bus.in_opcode, rd: bus.in_rd,
                   rs1: bus.in_rs1, rs2: bus.in_rs2, funct3: bus.in_funct3,
                   imm: bus.in_imm};
      if (state_q == ST_ENCODE) wdata_q <= word;
      if (state_q == ST_WRITE && bus.mem_ready) begin
        addr_q <= addr_q + ADDR_WIDTH'(4);
        cnt_q  <= cnt_q + CW'(1);
      end else if (state_q == ST_IDLE && clear) begin
        addr_q <= BASE_ADDR;
        cnt_q  <= '0;
      end
    end
  end
endmodule
